// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator with a shared frame counter,
// per-channel clamped targets, per-frame slew limiting and frame-aligned enables.
module servo_pwm_multi #(
  parameter int unsigned INPUT_FREQ   = 50_000_000,
  parameter int unsigned REFRESH_HZ   = 50,
  parameter int unsigned MIN_PULSE_NS = 1_000_000,
  parameter int unsigned MAX_PULSE_NS = 2_000_000,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DUTY_MAX     = 1000,
  parameter int unsigned SLEW_STEP    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [3:0]        wr_ch,
  input  logic [9:0]        wr_level,
  output logic              wr_ready,
  output logic              wr_err,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] busy,
  output logic              period_tick
);

  localparam logic [63:0] PERIOD_COUNT = 64'(INPUT_FREQ) / 64'(REFRESH_HZ);
  localparam logic [63:0] MIN_COUNT    = 64'(INPUT_FREQ) * 64'(MIN_PULSE_NS) / 64'd1_000_000_000;
  localparam logic [63:0] MAX_COUNT    = 64'(INPUT_FREQ) * 64'(MAX_PULSE_NS) / 64'd1_000_000_000;
  localparam int unsigned CNT_W        = (PERIOD_COUNT > 64'd1) ? $clog2(PERIOD_COUNT) : 1;
  // One extra bit lets a high-count equal to the full period still compare correctly.
  localparam int unsigned HC_W         = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_COUNT - 64'd1);
  localparam logic [9:0]  LVL_MAX      = 10'(DUTY_MAX);
  localparam int unsigned STEP_C       = (SLEW_STEP > 1023) ? 1023 : SLEW_STEP;
  localparam logic signed [11:0] STEP_S = 12'(STEP_C);
  localparam logic [9:0]  STEP_U       = 10'(STEP_C);

  function automatic logic [9:0] clamp_level(input logic [9:0] lvl);
    return (lvl > LVL_MAX) ? LVL_MAX : lvl;
  endfunction

  function automatic logic [9:0] slew_toward(input logic [9:0] p, input logic [9:0] t);
    logic signed [11:0] d;
    d = $signed({2'b00, t}) - $signed({2'b00, p});
    if ((SLEW_STEP == 0) || ((d <= STEP_S) && (d >= -STEP_S))) return t;
    else if (d > 12'sd0) return p + STEP_U;
    else return p - STEP_U;
  endfunction

  function automatic logic [HC_W-1:0] level_to_count(input logic [9:0] lvl);
    logic [63:0] cnt64;
    cnt64 = MIN_COUNT + ((MAX_COUNT - MIN_COUNT) * 64'(lvl)) / 64'(DUTY_MAX);
    return HC_W'(cnt64);
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [9:0]       target [NUM_CH];
  logic [9:0]       pos    [NUM_CH];
  logic [9:0]       pos_nx [NUM_CH];
  logic [HC_W-1:0]  hc     [NUM_CH];
  logic [NUM_CH-1:0] en_act;
  logic             frame_end;
  logic             wr_fire;
  logic             ch_ok;

  assign frame_end = (cnt == CNT_LAST);
  assign wr_fire   = wr_valid && wr_ready;
  assign ch_ok     = ({1'b0, wr_ch} < 5'(NUM_CH));

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pos_nx[i] = slew_toward(pos[i], target[i]);
      busy[i]   = (pos[i] != target[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      en_act      <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
      wr_err      <= 1'b0;
      wr_ready    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= '0;
        pos[i]    <= '0;
        hc[i]     <= '0;
      end
    end else begin
      wr_ready    <= 1'b1;
      wr_err      <= wr_fire && !ch_ok;
      period_tick <= (cnt == '0);
      cnt         <= frame_end ? '0 : cnt + 1'b1;

      // Output stage: pulse is high for the first hc counts of each frame.
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= en_act[i] && ({1'b0, cnt} < hc[i]);
      end

      // Frame boundary: slew positions, latch widths and enables together.
      if (frame_end) begin
        en_act <= ch_en;
        for (int i = 0; i < NUM_CH; i++) begin
          pos[i] <= pos_nx[i];
          hc[i]  <= level_to_count(pos_nx[i]);
        end
      end

      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_fire && ch_ok && (wr_ch == 4'(i))) begin
          target[i] <= clamp_level(wr_level);
        end
      end
    end
  end

endmodule

// File: doc/servo_pwm_multi.md
SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 Parameter INPUT_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter REFRESH_HZ, default 50, PWM frame rate in Hz; PERIOD_COUNT = INPUT_FREQ/REFRESH_HZ.
REQ-003 Parameter MIN_PULSE_NS, default 1_000_000; MIN_COUNT = INPUT_FREQ*MIN_PULSE_NS/1e9, computed at elaboration with 64-bit integer arithmetic.
REQ-004 Parameter MAX_PULSE_NS, default 2_000_000; MAX_COUNT computed the same way.
REQ-005 Parameter NUM_CH, default 4, number of servo channels (1..16).
REQ-006 Parameter DUTY_MAX, default 1000, full-scale level (1..1023).
REQ-007 Parameter SLEW_STEP, default 10, maximum position change per frame; 0 = no slew limit.
REQ-008 Signal clk, input, 1, sole clock; all state changes on rising edge.
REQ-009 Signal rst_n, input, 1, asynchronous active-low reset.
REQ-010 Signal wr_valid, input, 1, target-write request.
REQ-011 Signal wr_ch, input, 4, target channel index.
REQ-012 Signal wr_level, input, 10, requested level.
REQ-013 Signal wr_ready, output, 1, write acceptance.
REQ-014 Signal wr_err, output, 1, one-cycle pulse for a rejected write.
REQ-015 Signal ch_en, input, NUM_CH, per-channel enable request.
REQ-016 Signal pwm_out, output, NUM_CH, per-channel servo pulse, registered.
REQ-017 Signal busy, output, NUM_CH, per-channel "position != target" flag.
REQ-018 Signal period_tick, output, 1, one-cycle frame-start strobe.

Function
REQ-019 The free-running counter cnt SHALL count 0..PERIOD_COUNT-1 and wrap to 0; the wrap edge is the frame boundary.
REQ-020 wr_ready SHALL be 1 in every cycle after reset release; a write occurs on a cycle with wr_valid=1 and wr_ready=1.
REQ-021 For a write with wr_ch < NUM_CH, target[wr_ch] SHALL load min(wr_level, DUTY_MAX) on that edge.
REQ-022 For a write with wr_ch >= NUM_CH, no state other than wr_err SHALL change; wr_err SHALL be 1 in the following cycle only.
REQ-023 At each frame boundary, each channel position pos SHALL step toward the target value that held before that edge: if SLEW_STEP=0 or |target-pos| <= SLEW_STEP, pos becomes target; otherwise pos changes by exactly SLEW_STEP toward target.
REQ-024 A write coinciding with a frame boundary SHALL update target on that edge, but SHALL not influence that boundary's step.
REQ-025 At each frame boundary, hc[i] SHALL load MIN_COUNT + ((MAX_COUNT-MIN_COUNT)*pos_next[i])/DUTY_MAX, using unsigned arithmetic at least 32 bits wide with truncating division.
REQ-026 At each frame boundary, en_act[i] SHALL load ch_en[i]; ch_en changes SHALL have no effect mid-frame.
REQ-027 pwm_out[i] SHALL equal en_act[i] AND (k < hc[i]) in the cycle after cnt=k. Each enabled frame is exactly hc[i] cycles high, starting one cycle after cnt=0.
REQ-028 busy[i] SHALL equal (pos[i] != target[i]) from registered state, with no added latency.
REQ-029 period_tick SHALL be 1 exactly in the cycle after cnt=0.
REQ-030 Channels SHALL be fully independent; the same frame boundary updates all channels.

Reset
REQ-031 While rst_n=0, all of the following SHALL hold immediately, regardless of clk:
- cnt=0, pos=0, target=0, hc=0, en_act=0;
- pwm_out=0, busy=0, period_tick=0, wr_err=0, wr_ready=0.
REQ-032 Reset asserted mid-pulse SHALL drive pwm_out low at once; after release, the first frame SHALL output no pulse.

Verification
(Bench parameters: INPUT_FREQ=1_000_000, REFRESH_HZ=1000, MIN_PULSE_NS=100_000, MAX_PULSE_NS=200_000, so PERIOD_COUNT=1000, MIN_COUNT=100, MAX_COUNT=200.)
REQ-033 SLEW_STEP=0; ch_en=all 1s; write ch0 level 500 -> from the next frame, pwm_out[0] is high 150 cycles per 1000; other channels are 100 cycles high.
REQ-034 SLEW_STEP=100; write ch1 level 1000 from pos 0 -> successive frame widths 110,120,...,200; busy[1] falls at the 10th boundary; width remains 200 afterwards.
REQ-035 Write ch2 level 1023 -> target clamped to 1000; pulse 200 cycles once settled.
REQ-036 Write with wr_ch=NUM_CH -> wr_err=1 for one cycle; all pulse widths and busy flags unchanged.
REQ-037 ch_en[0] dropped mid-pulse -> current pulse completes at full width; next frame pwm_out[0]=0; re-enable takes effect at the following boundary.
REQ-038 rst_n pulsed low mid-pulse -> pwm_out=0 the same cycle; first frame after release has no pulse; period_tick resumes every 1000 cycles.
